// File: rtl/pc_ras_unit_pkg.sv
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared constants, next-PC select codes and the alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

   localparam int PC_INC   = 4;
   localparam int PC_MAX_W = 64;

   localparam logic [2:0] SEL_EXC  = 3'd0;
   localparam logic [2:0] SEL_HOLD = 3'd1;
   localparam logic [2:0] SEL_RET  = 3'd2;
   localparam logic [2:0] SEL_JR   = 3'd3;
   localparam logic [2:0] SEL_JMP  = 3'd4;
   localparam logic [2:0] SEL_BR   = 3'd5;
   localparam logic [2:0] SEL_SEQ  = 3'd6;

   // Callers widen to PC_MAX_W and narrow the result back to their own width.
   function automatic logic [PC_MAX_W-1:0] align4(input logic [PC_MAX_W-1:0] a);
      return a & ~PC_MAX_W'(3);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ras_unit_ras_stack.sv
// ============================================================================
// Module   : ras_stack
// Purpose  : Circular return-address stack; a full push drops the oldest entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
   parameter int W         = 10,
   parameter int RAS_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full,
   output logic         ovf_pulse,
   output logic         unf_pulse
);

   localparam int c_ptr_w = $clog2(RAS_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   logic [W-1:0]       r_mem [RAS_DEPTH];
   logic [c_ptr_w-1:0] r_ptr;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_ptr_w-1:0] w_ptr_inc;
   logic               w_do_push;
   logic               w_do_repl;
   logic               w_do_pop;

   assign empty     = (r_cnt == '0);
   assign full      = (r_cnt == c_cnt_w'(RAS_DEPTH));
   assign top       = r_mem[r_ptr];
   assign w_ptr_inc = r_ptr + c_ptr_w'(1);

   // A pop against an empty stack degrades a replace into a plain push.
   assign w_do_push = push & (~pop | empty);
   assign w_do_repl = push & pop & ~empty;
   assign w_do_pop  = ~push & pop & ~empty;

   assign ovf_pulse = w_do_push & full;
   assign unf_pulse = pop & empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_cnt <= '0;
      end else if (w_do_push) begin
         r_ptr <= w_ptr_inc;
         if (!full)
            r_cnt <= r_cnt + c_cnt_w'(1);
      end else if (w_do_pop) begin
         r_ptr <= r_ptr - c_ptr_w'(1);
         r_cnt <= r_cnt - c_cnt_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_do_push)
            r_mem[w_ptr_inc] <= push_data;
         else if (w_do_repl)
            r_mem[r_ptr] <= push_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_ras_unit.sv
// ============================================================================
// Module   : pc_ras_unit
// Purpose  : Fetch-stage next-PC generator with exception vector and RAS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras_unit
   import pc_pkg::*;
#(
   parameter int           W         = 10,
   parameter int           RAS_DEPTH = 4,
   parameter logic [W-1:0] EXC_VEC   = W'(10'h3F0)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] init_pc,
   input  logic         stall,
   input  logic         exc,
   input  logic         branch,
   input  logic         branch_ne,
   input  logic         zero,
   input  logic [W-1:0] offset,
   input  logic         jump,
   input  logic         jal,
   input  logic [W-1:0] j_address,
   input  logic         jr,
   input  logic         ret,
   input  logic [W-1:0] reg_target,
   output logic [W-1:0] pc,
   output logic [W-1:0] pc_plus4,
   output logic [W-1:0] epc,
   output logic         ras_empty,
   output logic         ras_full,
   output logic         ras_overflow,
   output logic         ras_underflow
);

   localparam logic [W-1:0] c_exc_vec = W'(align4(PC_MAX_W'(EXC_VEC)));

   logic [W-1:0] r_pc;
   logic [W-1:0] r_epc;
   logic         r_ovf;
   logic         r_unf;
   logic [W-1:0] w_pc_plus4;
   logic [W-1:0] w_pc_next;
   logic [2:0]   w_sel;
   logic         w_taken;
   logic         w_ras_act;
   logic         w_push;
   logic         w_pop;
   logic [W-1:0] w_ras_top;
   logic         w_ras_empty;
   logic         w_ras_full;
   logic         w_ovf_pulse;
   logic         w_unf_pulse;

   assign w_pc_plus4 = r_pc + W'(PC_INC);
   assign w_taken    = branch & (zero ^ branch_ne);

   always_comb begin
      w_sel = SEL_SEQ;
      if (exc)               w_sel = SEL_EXC;
      else if (stall)        w_sel = SEL_HOLD;
      else if (ret)          w_sel = SEL_RET;
      else if (jr)           w_sel = SEL_JR;
      else if (jal || jump)  w_sel = SEL_JMP;
      else if (w_taken)      w_sel = SEL_BR;
   end

   always_comb begin
      w_pc_next = w_pc_plus4;
      case (w_sel)
         SEL_EXC:  w_pc_next = c_exc_vec;
         SEL_HOLD: w_pc_next = r_pc;
         SEL_RET:  w_pc_next = w_ras_empty ? W'(align4(PC_MAX_W'(reg_target)))
                                           : W'(align4(PC_MAX_W'(w_ras_top)));
         SEL_JR:   w_pc_next = W'(align4(PC_MAX_W'(reg_target)));
         SEL_JMP:  w_pc_next = W'(align4(PC_MAX_W'(j_address)));
         SEL_BR:   w_pc_next = w_pc_plus4 + offset;
         default:  w_pc_next = w_pc_plus4;
      endcase
   end

   // jal pushes when it wins the mux or rides along with a ret (replace).
   assign w_ras_act = (w_sel != SEL_EXC) && (w_sel != SEL_HOLD);
   assign w_push    = w_ras_act & jal & (ret | ~jr);
   assign w_pop     = w_ras_act & ret;

   ras_stack #(
      .W         (W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_pc_plus4),
      .top       (w_ras_top),
      .empty     (w_ras_empty),
      .full      (w_ras_full),
      .ovf_pulse (w_ovf_pulse),
      .unf_pulse (w_unf_pulse)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc  <= init_pc;
         r_epc <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_pc <= w_pc_next;
         if (w_sel == SEL_EXC)
            r_epc <= r_pc;
         if (w_ovf_pulse)
            r_ovf <= 1'b1;
         if (w_unf_pulse)
            r_unf <= 1'b1;
      end
   end

   assign pc            = r_pc;
   assign pc_plus4      = w_pc_plus4;
   assign epc           = r_epc;
   assign ras_empty     = w_ras_empty;
   assign ras_full      = w_ras_full;
   assign ras_overflow  = r_ovf;
   assign ras_underflow = r_unf;

endmodule

`default_nettype wire
